clkdiv_prog: RTL

- Runtime-programmable, parametrised integer clock divider. Successor to the fixed divide-by-256 AON clock generator.
- Produces a registered divided clock `clk_out` and a one-cycle `tick` strobe per output period.
- Divisor is loaded through a valid/ready handshake and takes effect only at a period boundary, so the output never shows a runt pulse.
- Sits between the SoC clock and slow-clock consumers: AON 32.768 kHz, RTC, watchdog.

---
 rtl/clkdiv_prog_if.sv | 24 ++
 rtl/clkdiv_prog.sv | 112 +++++++++++
 2 files changed

// File: rtl/clkdiv_prog_if.sv
// Divisor-load handshake and divided-clock outputs of clkdiv_prog.
// The master side (controller) drives enable and the divisor request.
// The slave side (divider) returns ready, the divided clock, the tick and the active divisor.
interface clkdiv_prog_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic [WIDTH-1:0] div_value;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;

    modport master (
        output enable, div_value, div_valid,
        input  div_ready, clk_out, tick, cur_div
    );

    modport slave (
        input  enable, div_value, div_valid,
        output div_ready, clk_out, tick, cur_div
    );
endinterface

// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider.
// The output period is cur_div cycles: L = D - D/2 cycles low, then D/2 cycles high.
// A one-cycle tick marks each period start.
// A new divisor is taken through a valid/ready handshake and is only switched in at a
// period boundary, or right away while the divider is disabled, so no runt pulses occur.
// Optional build macro CLKDIV_SYNC_EN adds a sync_req input.
// sync_req forces a period restart, which lets several dividers be phase-aligned.
module clkdiv_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 256
) (
    input  logic           clk,
    input  logic           resetn,
`ifdef CLKDIV_SYNC_EN
    input  logic           sync_req,
`endif
    clkdiv_prog_if.slave   bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] cur_div_q;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] low_len;
    logic             pend_vld;
    logic             clk_q;
    logic             clk_nxt;
    logic             tick_q;
    logic             tick_nxt;
    logic             wrap;
    logic             rise;
    logic             accept;
    logic             apply;
    logic             sync_hit;

    // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v < WIDTH'(2)) ? WIDTH'(2) : v;
    endfunction

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync_req;
`else
    assign sync_hit = 1'b0;
`endif

    // The low phase takes the extra cycle when the divisor is odd.
    assign low_len = cur_div_q - (cur_div_q >> 1);
    assign wrap    = (cnt == cur_div_q - WIDTH'(1));
    assign rise    = (cnt == low_len - WIDTH'(1));
    assign accept  = bus.div_valid & ~pend_vld;

    // Next counter, output and divisor-switch decisions; the highest-priority event wins.
    always_comb begin
        cnt_nxt  = cnt;
        clk_nxt  = clk_q;
        tick_nxt = 1'b0;
        apply    = 1'b0;
        if (!bus.enable) begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
            apply   = pend_vld;
        end else if (sync_hit || wrap) begin
            cnt_nxt  = '0;
            clk_nxt  = 1'b0;
            tick_nxt = 1'b1;
            apply    = pend_vld;
        end else begin
            cnt_nxt = cnt + WIDTH'(1);
            if (rise) begin
                clk_nxt = 1'b1;
            end
        end
    end

    // Counter, registered outputs, active divisor and pending flag.
    // A value accepted on a wrap edge is not yet pending there, so it waits for the next wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            cur_div_q <= WIDTH'(DEFAULT_DIV);
            pend_vld  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            clk_q  <= clk_nxt;
            tick_q <= tick_nxt;
            if (apply) begin
                cur_div_q <= pend_div;
            end
            if (accept) begin
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Pending divisor data; it is only meaningful while pend_vld is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_div <= clamp_div(bus.div_value);
        end
    end

    assign bus.div_ready = ~pend_vld;
    assign bus.clk_out   = clk_q;
    assign bus.tick      = tick_q;
    assign bus.cur_div   = cur_div_q;

endmodule
